cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the processor core under top_level.
- Drives the program counter and instruction-register load.
- Gates register-file writes and data-memory (dm1) enables.
- Raises done on a halt instruction, so benches run as "pulse reset, wait(done), check dm1.core".

Parameters:
PC_W, 10, program counter width; PC arithmetic is modulo 2^PC_W
OFF_W, 8, signed relative-branch offset width (two's complement, sign-extended to PC_W)
MEM_LAT, 1, data-memory read latency in cycles after the EXEC cycle; legal range 0..3
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
halt_i  in  1  decoded instruction is HALT (valid in EXEC)
mem_op_i  in  1  decoded instruction accesses data memory (valid in EXEC)
mem_rd_i  in  1  1 = load, 0 = store; qualified by mem_op_i
branch_i  in  1  conditional relative branch (valid in EXEC)
zero_i  in  1  branch condition flag from ALU/flag reg (valid in EXEC)
jump_abs_i  in  1  absolute jump (valid in EXEC)
target_i  in  PC_W  absolute jump target
offset_i  in  OFF_W  signed relative branch offset
pc_o  out  PC_W  instruction-memory address (registered)
ir_load_o  out  1  latch instruction register this cycle
mem_en_o  out  1  data-memory access strobe
reg_we_en_o  out  1  permits register-file write this cycle
done  out  1  processor halted (sticky until reset)
instr_cnt_o  out  CNT_W  retired instructions, saturating

Behaviour:
- States: FETCH, EXEC, WAIT, HALT.
- Reset (reset=1 at a rising edge): state=FETCH, pc_o=0, instr_cnt_o=0, done=0, wait counter=0.
- While reset is high, ir_load_o, mem_en_o and reg_we_en_o are forced to 0.
- FETCH: ir_load_o=1, all other strobes 0; next state EXEC. Decode inputs are ignored.
- EXEC, with priority halt > memory > plain:
  - halt_i=1: next state HALT. pc_o is unchanged. All strobes 0, even if mem_op_i or branch_i is also set. Not counted as retired.
  - mem_op_i=1 and mem_rd_i=0 (store): mem_en_o=1, reg_we_en_o=0. Retires this cycle; next state FETCH.
  - mem_op_i=1 and mem_rd_i=1 (load): mem_en_o=1.
    - MEM_LAT=0: reg_we_en_o=1 and retires this cycle.
    - MEM_LAT>0: reg_we_en_o=0; next state WAIT with wait counter loaded to MEM_LAT-1.
  - Otherwise (ALU/branch/jump): reg_we_en_o=1 unless branch_i or jump_abs_i is set (those write no register). Retires this cycle.
- WAIT: mem_en_o=0.
  - Counter nonzero: decrement, stay in WAIT.
  - Counter zero: reg_we_en_o=1, retire, next state FETCH.
- Retire: pc_o updates at the end of the retiring cycle, and instr_cnt_o increments, saturating at 2^CNT_W-1. Next-PC priority:
  1. jump_abs_i: target_i
  2. branch_i & zero_i: pc_o + sext(offset_i) mod 2^PC_W
  3. otherwise: pc_o + 1 mod 2^PC_W (0x3FF -> 0x000)
- Decode inputs for a load are sampled in EXEC and held internally through WAIT, so the datapath may change them.
- HALT: done=1 from the first cycle in HALT. All strobes 0. pc_o and instr_cnt_o frozen. All inputs ignored. Only reset exits.
- Reset mid-operation (any state, including WAIT): returns to FETCH at pc 0 on the next edge. No pending load completes, and no reg_we_en_o pulse follows.
- Throughput: 2 cycles per non-load instruction; 2+MEM_LAT cycles per load.

Decomposition:
- Package cpu_ctrl_pkg: seq_state_t enum {FETCH, EXEC, WAIT, HALT}, and default constants PC_W/OFF_W/MEM_LAT/CNT_W.
- Sub-module pc_next_calc: combinational next-PC mux and sign-extending adder, parameterised by PC_W and OFF_W.
- FSM, wait counter and retire counter stay in cpu_sequencer.

Test Plan:
1. Reset, then three plain instructions (all decode inputs 0) -> pc_o 0,0,1,1,2,2,3 across FETCH/EXEC; ir_load_o on FETCH cycles; reg_we_en_o on EXEC cycles; instr_cnt_o=3; done=0.
2. MEM_LAT=2, load at pc=0 -> EXEC: mem_en_o=1, reg_we_en_o=0; WAIT 2 cycles with reg_we_en_o=1 only on the second; pc_o=1 after 4 cycles total. Store at pc=1 -> mem_en_o=1, reg_we_en_o=0, 2 cycles.
3. Branch at pc=5, offset 8'hFD, zero_i=1 -> pc_o=2; zero_i=0 -> pc_o=6. Jump target 10'h3FF, then a plain instruction -> pc_o wraps to 0.
4. Halt at pc=4 -> done=1 the cycle after EXEC; pc_o stays 4; strobes 0 for 20 cycles of random decode inputs; instr_cnt_o unchanged.
5. Reset asserted during WAIT (MEM_LAT=3) -> next edge: pc_o=0, instr_cnt_o=0, done=0, ir_load_o=1 the cycle after deassert, no reg_we_en_o pulse.
6. halt_i, mem_op_i, mem_rd_i and branch_i all 1 in EXEC -> mem_en_o=0, reg_we_en_o=0, HALT entered, pc_o unchanged.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default sizes for the multi-cycle core sequencer.
// Imported by the sequencer and its next-PC helper.
package cpu_ctrl_pkg;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_OFF_W   = 8;
    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAIT,
        HALT
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_pc_next.sv
// Next-PC selection: absolute jump, taken relative branch, or increment.
// Purely combinational; all arithmetic wraps modulo 2^PC_W.
module pc_next_calc #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump_abs,
    input  logic [PC_W-1:0]  target,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] off_ext;

    assign off_ext = PC_W'($signed(offset));

    // Jump beats a taken branch, which beats the sequential increment
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (jump_abs) begin
            pc_next = target;
        end else if (branch && zero) begin
            pc_next = pc + off_ext;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/WAIT/HALT control for the core: PC, IR load,
// data-memory and register-write strobes, halt flag, retire counter.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int OFF_W   = DEF_OFF_W,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt_i,
    input  logic             mem_op_i,
    input  logic             mem_rd_i,
    input  logic             branch_i,
    input  logic             zero_i,
    input  logic             jump_abs_i,
    input  logic [PC_W-1:0]  target_i,
    input  logic [OFF_W-1:0] offset_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             ir_load_o,
    output logic             mem_en_o,
    output logic             reg_we_en_o,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam logic [1:0] WAIT_INIT =
        (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t      state;
    logic [1:0]      wait_cnt;
    logic [PC_W-1:0] pc_pend;
    logic [PC_W-1:0] pc_next;
    logic            retire;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .pc       (pc_o),
        .branch   (branch_i),
        .zero     (zero_i),
        .jump_abs (jump_abs_i),
        .target   (target_i),
        .offset   (offset_i),
        .pc_next  (pc_next)
    );

    // Strobes follow the current state and EXEC decode; reset kills them all
    always_comb begin
        ir_load_o   = 1'b0;
        mem_en_o    = 1'b0;
        reg_we_en_o = 1'b0;
        retire      = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: ir_load_o = 1'b1;
                EXEC: begin
                    if (halt_i) begin
                        retire = 1'b0;
                    end else if (mem_op_i) begin
                        mem_en_o = 1'b1;
                        if (!mem_rd_i) begin
                            retire = 1'b1;
                        end else if (MEM_LAT == 0) begin
                            reg_we_en_o = 1'b1;
                            retire      = 1'b1;
                        end
                    end else begin
                        reg_we_en_o = !(branch_i || jump_abs_i);
                        retire      = 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        reg_we_en_o = 1'b1;
                        retire      = 1'b1;
                    end
                end
                default: retire = 1'b0;
            endcase
        end
    end

    // State machine, load-wait countdown, PC and saturating retire count
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc_o        <= '0;
            pc_pend     <= '0;
            wait_cnt    <= 2'd0;
            done        <= 1'b0;
            instr_cnt_o <= '0;
        end else begin
            unique case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    if (halt_i) begin
                        state <= HALT;
                        done  <= 1'b1;
                    end else if (mem_op_i && mem_rd_i && MEM_LAT > 0) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                        pc_pend  <= pc_next;
                    end else begin
                        state <= FETCH;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: state <= HALT;
            endcase
            if (retire) begin
                pc_o <= (state == WAIT) ? pc_pend : pc_next;
                if (instr_cnt_o != CNT_MAX) begin
                    instr_cnt_o <= instr_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table for the main flows,
// hand sequences for halt, reset-in-WAIT and counter saturation.
module tb_cpu_sequencer;

    typedef struct {
        logic [6:0] ctl;
        logic [9:0] tgt;
        logic [7:0] off;
        logic [9:0] pc;
        logic [3:0] st;
        logic [3:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       halt_i, mem_op_i, mem_rd_i;
    logic       branch_i, zero_i, jump_abs_i;
    logic [9:0] target_i;
    logic [7:0] offset_i;
    logic [9:0] pc_o;
    logic       ir_load_o, mem_en_o, reg_we_en_o, done;
    logic [3:0] instr_cnt_o;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t tbl[34];

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PC_W    (10),
        .OFF_W   (8),
        .MEM_LAT (2),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt_i      (halt_i),
        .mem_op_i    (mem_op_i),
        .mem_rd_i    (mem_rd_i),
        .branch_i    (branch_i),
        .zero_i      (zero_i),
        .jump_abs_i  (jump_abs_i),
        .target_i    (target_i),
        .offset_i    (offset_i),
        .pc_o        (pc_o),
        .ir_load_o   (ir_load_o),
        .mem_en_o    (mem_en_o),
        .reg_we_en_o (reg_we_en_o),
        .done        (done),
        .instr_cnt_o (instr_cnt_o)
    );

    // ctl = {reset, halt, mem_op, mem_rd, branch, zero, jump}
    // st  = {ir_load, mem_en, reg_we_en, done}
    function automatic vec_t mk(input logic [6:0] ctl,
                                input logic [9:0] tgt,
                                input logic [7:0] off,
                                input logic [9:0] pc,
                                input logic [3:0] st,
                                input logic [3:0] cnt);
        vec_t v;
        v.ctl = ctl;
        v.tgt = tgt;
        v.off = off;
        v.pc  = pc;
        v.st  = st;
        v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, compare at mid-cycle
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        {reset, halt_i, mem_op_i, mem_rd_i,
         branch_i, zero_i, jump_abs_i} = v.ctl;
        target_i = v.tgt;
        offset_i = v.off;
        exp_q.push_back(v);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if ({pc_o, ir_load_o, mem_en_o, reg_we_en_o, done,
                 instr_cnt_o} !== {e.pc, e.st, e.cnt}) begin
                errors++;
                $display("FAIL %s: got pc=%h ir/men/we/done=%b%b%b%b cnt=%0d want pc=%h st=%b cnt=%0d",
                         name, pc_o, ir_load_o, mem_en_o, reg_we_en_o,
                         done, instr_cnt_o, e.pc, e.st, e.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ce;
        tbl[0]  = mk(7'b1000000, 10'h000, 8'h00, 10'h000, 4'b0000, 4'd0);
        tbl[1]  = mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b1000, 4'd0);
        tbl[2]  = mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b0010, 4'd0);
        tbl[3]  = mk(7'b0011001, 10'h2AA, 8'h00, 10'h001, 4'b1000, 4'd1);
        tbl[4]  = mk(7'b0000000, 10'h000, 8'h00, 10'h001, 4'b0010, 4'd1);
        tbl[5]  = mk(7'b0000000, 10'h000, 8'h00, 10'h002, 4'b1000, 4'd2);
        tbl[6]  = mk(7'b0000000, 10'h000, 8'h00, 10'h002, 4'b0010, 4'd2);
        tbl[7]  = mk(7'b0000000, 10'h000, 8'h00, 10'h003, 4'b1000, 4'd3);
        tbl[8]  = mk(7'b1000000, 10'h000, 8'h00, 10'h003, 4'b0000, 4'd3);
        tbl[9]  = mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b1000, 4'd0);
        tbl[10] = mk(7'b0011000, 10'h000, 8'h00, 10'h000, 4'b0100, 4'd0);
        tbl[11] = mk(7'b0000001, 10'h155, 8'h00, 10'h000, 4'b0000, 4'd0);
        tbl[12] = mk(7'b0000110, 10'h000, 8'h10, 10'h000, 4'b0010, 4'd0);
        tbl[13] = mk(7'b0000000, 10'h000, 8'h00, 10'h001, 4'b1000, 4'd1);
        tbl[14] = mk(7'b0010000, 10'h000, 8'h00, 10'h001, 4'b0100, 4'd1);
        tbl[15] = mk(7'b0000000, 10'h000, 8'h00, 10'h002, 4'b1000, 4'd2);
        tbl[16] = mk(7'b0000001, 10'h005, 8'h00, 10'h002, 4'b0000, 4'd2);
        tbl[17] = mk(7'b0000000, 10'h000, 8'h00, 10'h005, 4'b1000, 4'd3);
        tbl[18] = mk(7'b0000110, 10'h000, 8'hFD, 10'h005, 4'b0000, 4'd3);
        tbl[19] = mk(7'b0000000, 10'h000, 8'h00, 10'h002, 4'b1000, 4'd4);
        tbl[20] = mk(7'b0000001, 10'h005, 8'h00, 10'h002, 4'b0000, 4'd4);
        tbl[21] = mk(7'b0000000, 10'h000, 8'h00, 10'h005, 4'b1000, 4'd5);
        tbl[22] = mk(7'b0000100, 10'h000, 8'hFD, 10'h005, 4'b0000, 4'd5);
        tbl[23] = mk(7'b0000000, 10'h000, 8'h00, 10'h006, 4'b1000, 4'd6);
        tbl[24] = mk(7'b0000111, 10'h3FF, 8'h20, 10'h006, 4'b0000, 4'd6);
        tbl[25] = mk(7'b0000000, 10'h000, 8'h00, 10'h3FF, 4'b1000, 4'd7);
        tbl[26] = mk(7'b0000000, 10'h000, 8'h00, 10'h3FF, 4'b0010, 4'd7);
        tbl[27] = mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b1000, 4'd8);
        tbl[28] = mk(7'b0000110, 10'h000, 8'hFF, 10'h000, 4'b0000, 4'd8);
        tbl[29] = mk(7'b0000000, 10'h000, 8'h00, 10'h3FF, 4'b1000, 4'd9);
        tbl[30] = mk(7'b0000001, 10'h004, 8'h00, 10'h3FF, 4'b0000, 4'd9);
        tbl[31] = mk(7'b0000000, 10'h000, 8'h00, 10'h004, 4'b1000, 4'd10);
        tbl[32] = mk(7'b0111110, 10'h000, 8'h00, 10'h004, 4'b0000, 4'd10);
        tbl[33] = mk(7'b0011000, 10'h000, 8'h00, 10'h004, 4'b0001, 4'd10);

        {reset, halt_i, mem_op_i, mem_rd_i,
         branch_i, zero_i, jump_abs_i} = 7'b1000000;
        target_i = '0;
        offset_i = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 34; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            apply(mk({1'b0, 6'($urandom)}, 10'($urandom), 8'($urandom),
                     10'h004, 4'b0001, 4'd10),
                  $sformatf("halt_hold%0d", i));
        end

        apply(mk(7'b1000000, 10'h000, 8'h00, 10'h004, 4'b0001, 4'd10), "rst_from_halt");
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b1000, 4'd0), "post_rst_fetch");
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b0010, 4'd0), "plain_exec");
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'h001, 4'b1000, 4'd1), "fetch1");
        apply(mk(7'b0011000, 10'h000, 8'h00, 10'h001, 4'b0100, 4'd1), "load_exec");
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'h001, 4'b0000, 4'd1), "wait1");
        apply(mk(7'b1000000, 10'h000, 8'h00, 10'h001, 4'b0000, 4'd1), "rst_in_wait");
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b1000, 4'd0), "fetch_after_wait_rst");
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'h000, 4'b0010, 4'd0), "exec_after_wait_rst");

        for (int i = 1; i < 20; i++) begin
            ce = (i > 15) ? 4'd15 : 4'(i);
            apply(mk(7'b0000000, 10'h000, 8'h00, 10'(i), 4'b1000, ce),
                  $sformatf("sat_fetch%0d", i));
            apply(mk(7'b0000000, 10'h000, 8'h00, 10'(i), 4'b0010, ce),
                  $sformatf("sat_exec%0d", i));
        end
        apply(mk(7'b0000000, 10'h000, 8'h00, 10'd20, 4'b1000, 4'd15), "sat_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
